// File: rtl/logring_pkg.sv
// Shared definitions for the logring log buffer.
//   - Register address map (DATA, CTRL/STATUS, PTRS, MODE).
//   - CTRL command bit positions and a decoder to a packed command struct.
//   - STATUS and PTRS field positions for the read-back words.
package logring_pkg;

    // Register select values on addr.
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_PTRS = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    // CTRL write command bits.
    localparam int unsigned CTRL_COMMIT_BIT  = 0;
    localparam int unsigned CTRL_RELEASE_BIT = 1;
    localparam int unsigned CTRL_CLEAR_BIT   = 2;
    localparam int unsigned CTRL_REWIND_BIT  = 3;

    // STATUS read fields.
    localparam int unsigned STAT_GET_LSB   = 0;
    localparam int unsigned STAT_PUT_LSB   = 8;
    localparam int unsigned STAT_COUNT_LSB = 16;
    localparam int unsigned STAT_FULL_BIT  = 30;
    localparam int unsigned STAT_EMPTY_BIT = 31;

    // PTRS read fields.
    localparam int unsigned PTRS_RD_LSB  = 0;
    localparam int unsigned PTRS_WR_LSB  = 8;
    localparam int unsigned PTRS_OVF_LSB = 16;

    // MODE register bit.
    localparam int unsigned MODE_OVW_BIT = 0;

    typedef struct packed {
        logic rewind;
        logic clear;
        logic rel;
        logic commit;
    } ctrl_cmd_t;

    function automatic ctrl_cmd_t decode_ctrl(input logic [31:0] wdata);
        ctrl_cmd_t cmd;
        cmd.commit = wdata[CTRL_COMMIT_BIT];
        cmd.rel    = wdata[CTRL_RELEASE_BIT];
        cmd.clear  = wdata[CTRL_CLEAR_BIT];
        cmd.rewind = wdata[CTRL_REWIND_BIT];
        return cmd;
    endfunction

endpackage

// File: rtl/logring_mem.sv
// Simple dual-port RAM backing the log entries.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, valid the cycle after re
// No reset on storage or read register so it maps onto block RAM.
module logring_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/logring.sv
// Ring of log entries, each a fixed number of data slots, behind a small register bus.
//   clk      : clock, rst : asynchronous active-high reset
//   stb      : bus strobe, held until ack
//   we       : 1 = write, 0 = read
//   addr     : 0 DATA, 1 CTRL/STATUS, 2 PTRS, 3 MODE
//   data_in  : write data
//   data_out : read data, zero unless a read is acked this cycle
//   ack      : transfer complete (DATA reads take one wait state)
// The producer fills entry put_ix slot by slot and COMMITs it; the consumer reads
// entry get_ix slot by slot and RELEASEs it. One entry is kept in reserve so the
// entry being filled never aliases one still waiting to be read.
module logring
    import logring_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned NUM_SLOTS   = 64,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OVERWRITE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack
);

    localparam int unsigned EW = $clog2(NUM_ENTRIES);
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned AW = EW + SW;

    localparam logic [EW-1:0] IX_ONE     = EW'(1);
    localparam logic [SW-1:0] PTR_ONE    = SW'(1);
    localparam logic [7:0]    FULL_COUNT = 8'(NUM_ENTRIES - 1);

    logic [EW-1:0] put_ix_q, put_ix_d;
    logic [EW-1:0] get_ix_q, get_ix_d;
    logic [SW-1:0] wr_ptr_q, wr_ptr_d;
    logic [SW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    count_q, count_d;
    logic [15:0]   ovf_cnt_q, ovf_cnt_d;
    logic          mode_ovw_q, mode_ovw_d;
    logic          rd_pend_q, rd_pend_d;

    logic          bus_stb;
    logic          is_data;
    logic          data_wr;
    logic          data_rd_issue;
    logic          data_rd_done;
    logic          ctrl_wr;
    logic          mode_wr;
    logic          full;
    logic          empty;
    ctrl_cmd_t     cmd;

    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [31:0]           status_word;
    logic [31:0]           ptrs_word;

    // Nothing on the bus is honoured while reset is held.
    assign bus_stb = stb && !rst;
    assign is_data = (addr == ADDR_DATA);

    assign data_wr       = bus_stb && we && is_data;
    assign data_rd_issue = bus_stb && !we && is_data && !rd_pend_q;
    assign data_rd_done  = bus_stb && !we && is_data && rd_pend_q;
    assign ctrl_wr       = bus_stb && we && (addr == ADDR_CTRL);
    assign mode_wr       = bus_stb && we && (addr == ADDR_MODE);

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == 8'd0);
    assign cmd   = decode_ctrl(data_in);

    logring_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(AW)
    ) u_mem (
        .clk  (clk),
        .we   (data_wr),
        .waddr({put_ix_q, wr_ptr_q}),
        .wdata(data_in[DATA_WIDTH-1:0]),
        .re   (data_rd_issue),
        .raddr({get_ix_q, rd_ptr_q}),
        .rdata(mem_rdata)
    );

    // Next-state for indices, pointers and counters.
    always_comb begin
        put_ix_d   = put_ix_q;
        get_ix_d   = get_ix_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_cnt_d  = ovf_cnt_q;
        mode_ovw_d = mode_ovw_q;
        // Pending only for the cycle after issue; dropping stb or completing clears it.
        rd_pend_d  = data_rd_issue;

        if (data_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (data_rd_done) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (mode_wr) begin
            mode_ovw_d = data_in[MODE_OVW_BIT];
        end

        if (ctrl_wr) begin
            if (cmd.clear) begin
                put_ix_d  = '0;
                get_ix_d  = '0;
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                count_d   = '0;
                ovf_cnt_d = '0;
            end else begin
                if (cmd.rel && !empty) begin
                    get_ix_d = get_ix_q + IX_ONE;
                    count_d  = count_q - 8'd1;
                    rd_ptr_d = '0;
                end

                // Commit sees the count after any release in the same write.
                if (cmd.commit) begin
                    if (count_d != FULL_COUNT) begin
                        put_ix_d = put_ix_q + IX_ONE;
                        count_d  = count_d + 8'd1;
                        wr_ptr_d = '0;
                    end else begin
                        if (mode_ovw_q) begin
                            // Drop the oldest entry to make room.
                            put_ix_d = put_ix_q + IX_ONE;
                            get_ix_d = get_ix_d + IX_ONE;
                            rd_ptr_d = '0;
                        end
                        // Without overwrite the entry being filled is discarded.
                        wr_ptr_d = '0;
                        if (ovf_cnt_q != 16'hFFFF) begin
                            ovf_cnt_d = ovf_cnt_q + 16'd1;
                        end
                    end
                end

                if (cmd.rewind) begin
                    rd_ptr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            put_ix_q   <= '0;
            get_ix_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_cnt_q  <= '0;
            mode_ovw_q <= (OVERWRITE != 0);
            rd_pend_q  <= 1'b0;
        end else begin
            put_ix_q   <= put_ix_d;
            get_ix_q   <= get_ix_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_cnt_q  <= ovf_cnt_d;
            mode_ovw_q <= mode_ovw_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Read-back words.
    always_comb begin
        status_word                                = '0;
        status_word[STAT_GET_LSB +: EW]            = get_ix_q;
        status_word[STAT_PUT_LSB +: EW]            = put_ix_q;
        status_word[STAT_COUNT_LSB +: 8]           = count_q;
        status_word[STAT_FULL_BIT]                 = full;
        status_word[STAT_EMPTY_BIT]                = empty;

        ptrs_word                                  = '0;
        ptrs_word[PTRS_RD_LSB +: SW]               = rd_ptr_q;
        ptrs_word[PTRS_WR_LSB +: SW]               = wr_ptr_q;
        ptrs_word[PTRS_OVF_LSB +: 16]              = ovf_cnt_q;
    end

    // Bus response: everything but a DATA read acks in the same cycle.
    always_comb begin
        ack      = 1'b0;
        data_out = '0;
        if (bus_stb) begin
            if (is_data && !we) begin
                ack = rd_pend_q;
                if (rd_pend_q) begin
                    data_out[DATA_WIDTH-1:0] = mem_rdata;
                end
            end else begin
                ack = 1'b1;
                if (!we) begin
                    unique case (addr)
                        ADDR_CTRL: data_out = status_word;
                        ADDR_PTRS: data_out = ptrs_word;
                        ADDR_MODE: data_out[MODE_OVW_BIT] = mode_ovw_q;
                        default:   data_out = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_logring.sv
// Scoreboard bench for logring (4 entries x 4 slots x 8 bits).
// Reads push their expected word; a negedge monitor pops and compares on each read ack.
module tb_logring;
    import logring_pkg::*;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    int checks;
    int errors;

    string       name_q[$];
    logic [31:0] val_q[$];

    logring #(
        .NUM_ENTRIES(4),
        .NUM_SLOTS  (4),
        .DATA_WIDTH (8),
        .OVERWRITE  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .stb     (stb),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .ack     (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every acked read against the scoreboard; otherwise data_out must be 0.
    always @(negedge clk) begin
        if (ack && stb && !we) begin
            checks++;
            if (val_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got %08h, required no read", data_out);
            end else begin
                string       nm;
                logic [31:0] ev;
                nm = name_q.pop_front();
                ev = val_q.pop_front();
                if (data_out !== ev) begin
                    errors++;
                    $display("FAIL %s: got %08h, required %08h", nm, data_out, ev);
                end
            end
        end else begin
            checks++;
            if (data_out !== 32'h0) begin
                errors++;
                $display("FAIL idle_data_out: got %08h, required 00000000", data_out);
            end
        end
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input string nm, input logic [31:0] ev);
        int n;
        int lat;
        lat = (!w && a == ADDR_DATA) ? 2 : 1;
        if (!w) begin
            name_q.push_back(nm);
            val_q.push_back(ev);
        end
        stb     = 1'b1;
        we      = w;
        addr    = a;
        data_in = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        checks++;
        if (!ack) begin
            errors++;
            $display("FAIL %s_timeout: got no ack, required ack", nm);
            if (!w) begin
                void'(name_q.pop_back());
                void'(val_q.pop_back());
            end
        end else if (n != lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", nm, n, lat);
        end
        @(posedge clk);
        #1;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string nm);
        bus(1'b1, a, d, nm, 32'h0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] ev, input string nm);
        bus(1'b0, a, 32'h0, nm, ev);
    endtask

    // CLEAR, then commit three entries whose slot 0 holds A0, A1, A2.
    task automatic fill3();
        wr(ADDR_CTRL, 32'h4, "clear");
        for (int i = 0; i < 3; i++) begin
            wr(ADDR_DATA, 32'hA0 + 32'(i), "fill_data");
            wr(ADDR_CTRL, 32'h1, "fill_commit");
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        stb     = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        data_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        rd(ADDR_CTRL, 32'h8000_0000, "rst_status");
        rd(ADDR_PTRS, 32'h0000_0000, "rst_ptrs");
        rd(ADDR_MODE, 32'h0000_0001, "rst_mode");

        // Basic write, commit, read.
        wr(ADDR_DATA, 32'hFFFF_FF11, "w11");
        wr(ADDR_DATA, 32'h22, "w22");
        wr(ADDR_CTRL, 32'h1, "commit");
        rd(ADDR_DATA, 32'h11, "rd_11");
        rd(ADDR_DATA, 32'h22, "rd_22");
        rd(ADDR_CTRL, 32'h0001_0100, "basic_status");
        rd(ADDR_PTRS, 32'h0000_0002, "basic_ptrs");

        // Full with overwrite: oldest dropped.
        fill3();
        rd(ADDR_CTRL, 32'h4003_0300, "full_status");
        wr(ADDR_DATA, 32'hA3, "wA3");
        wr(ADDR_CTRL, 32'h1, "ovw_commit");
        rd(ADDR_CTRL, 32'h4003_0001, "ovw_status");
        rd(ADDR_PTRS, 32'h0001_0000, "ovw_ptrs");
        rd(ADDR_DATA, 32'hA1, "ovw_data");

        // Full without overwrite: new entry discarded.
        wr(ADDR_MODE, 32'h0, "mode0");
        rd(ADDR_MODE, 32'h0, "mode0_rd");
        fill3();
        wr(ADDR_DATA, 32'hA3, "wA3_nov");
        wr(ADDR_CTRL, 32'h1, "nov_commit");
        rd(ADDR_CTRL, 32'h4003_0300, "nov_status");
        rd(ADDR_PTRS, 32'h0001_0000, "nov_ptrs");
        rd(ADDR_DATA, 32'hA0, "nov_data");

        // Release+commit while full: no overflow.
        wr(ADDR_CTRL, 32'h3, "rel_commit");
        rd(ADDR_CTRL, 32'h4003_0001, "relc_status");
        rd(ADDR_PTRS, 32'h0001_0000, "relc_ptrs");

        // Release while empty: no change.
        wr(ADDR_CTRL, 32'h4, "clear2");
        wr(ADDR_DATA, 32'h99, "w99");
        wr(ADDR_CTRL, 32'h2, "rel_empty");
        rd(ADDR_CTRL, 32'h8000_0000, "rel_empty_status");
        rd(ADDR_PTRS, 32'h0000_0100, "rel_empty_ptrs");

        // Rewind re-reads slot 0.
        wr(ADDR_CTRL, 32'h4, "clear3");
        wr(ADDR_DATA, 32'h55, "w55");
        wr(ADDR_CTRL, 32'h1, "commit55");
        rd(ADDR_DATA, 32'h55, "rd_55");
        wr(ADDR_CTRL, 32'h8, "rewind");
        rd(ADDR_PTRS, 32'h0000_0000, "rewind_ptrs");
        rd(ADDR_DATA, 32'h55, "rd_55_again");

        // Overflow count to 5, then CLEAR.
        wr(ADDR_CTRL, 32'h4, "clear4");
        for (int i = 0; i < 8; i++) begin
            wr(ADDR_CTRL, 32'h1, "ovf_commit");
        end
        rd(ADDR_PTRS, 32'h0005_0000, "ovf5_ptrs");
        wr(ADDR_CTRL, 32'h4, "clear5");
        rd(ADDR_PTRS, 32'h0000_0000, "clear_ptrs");
        rd(ADDR_CTRL, 32'h8000_0000, "clear_status");
        rd(ADDR_MODE, 32'h0, "clear_mode");

        // Reset during a pending DATA read.
        wr(ADDR_DATA, 32'h77, "w77");
        wr(ADDR_CTRL, 32'h1, "commit77");
        stb  = 1'b1;
        we   = 1'b0;
        addr = ADDR_DATA;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_read_ack: got %b, required 0", ack);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_read_ack2: got %b, required 0", ack);
        end
        @(posedge clk);
        #1;
        stb = 1'b0;
        rst = 1'b0;
        rd(ADDR_CTRL, 32'h8000_0000, "post_rst_status");
        rd(ADDR_PTRS, 32'h0000_0000, "post_rst_ptrs");
        rd(ADDR_MODE, 32'h0000_0001, "post_rst_mode");

        repeat (2) @(posedge clk);
        checks++;
        if (val_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", val_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
